apb_usrt_fifo: RTL and testbench

- Parametrised APB-slave USRT peripheral; successor to the fixed 8-bit APB/USRT top.
- Contains a programmable baud/bit-clock generator, TX and RX FIFOs of configurable depth, and configurable frame width.
- Adds a status register, sticky error flags, loopback and an interrupt output.
- Sits on the APB bus and drives the external Tx/uClk pins.

---
 rtl/apb_usrt_fifo.sv | 340 ++++++++++++++++++++++++++++++++++
 tb/tb_apb_usrt_fifo.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_usrt_fifo.sv
// APB-slave USRT with programmable bit clock, TX/RX FIFOs, status/sticky
// error flags, loopback and a level interrupt.
// Ports:
//   pClk, pReset            : APB clock, async active-low reset
//   pSelect/pEnable/pWrite  : APB control; pAddress[3:2] selects the register
//   pWData/pRData           : APB write data / combinational read data
//   pReady, pSlvErr         : always ready; error on DATA write-full / read-empty
//   Rx, Tx, uClk            : serial in, serial out, bit clock to link partner
//   irq                     : level interrupt (RX data available / sticky errors)
module apb_usrt_fifo #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned DIV_W       = 16,
  parameter int unsigned DEFAULT_DIV = 7
) (
  input  logic        pClk,
  input  logic        pReset,
  input  logic        pSelect,
  input  logic        pEnable,
  input  logic        pWrite,
  input  logic [3:0]  pAddress,
  input  logic [15:0] pWData,
  output logic [15:0] pRData,
  output logic        pReady,
  output logic        pSlvErr,
  input  logic        Rx,
  output logic        Tx,
  output logic        uClk,
  output logic        irq
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_DIV    = 2'd2;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} txState_t;
  typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_STOP} rxState_t;

  // APB decode
  logic       access, regWr, regRd;
  logic [1:0] regSel;
  logic       dataWr, dataRd, statusWr, divWr, ctrlWr;

  assign access   = pSelect & pEnable;
  assign regWr    = access & pWrite;
  assign regRd    = access & ~pWrite;
  assign regSel   = pAddress[3:2];
  assign dataWr   = regWr & (regSel == ADDR_DATA);
  assign dataRd   = regRd & (regSel == ADDR_DATA);
  assign statusWr = regWr & (regSel == ADDR_STATUS);
  assign divWr    = regWr & (regSel == ADDR_DIV);
  assign ctrlWr   = regWr & (regSel == 2'd3);
  assign pReady   = 1'b1;

  logic unusedBits;
  assign unusedBits = ^{pAddress[1:0], pWData};

  // Configuration registers
  logic [DIV_W-1:0] divReg;
  logic [4:0]       ctrl;
  logic             txEn, rxEn, loopback, ieRx, ieErr;

  assign txEn     = ctrl[0];
  assign rxEn     = ctrl[1];
  assign loopback = ctrl[2];
  assign ieRx     = ctrl[3];
  assign ieErr    = ctrl[4];

  always_ff @(posedge pClk or negedge pReset) begin
    if (!pReset) begin
      divReg <= DIV_W'(DEFAULT_DIV);
      ctrl   <= '0;
    end else begin
      if (divWr)  divReg <= pWData[DIV_W-1:0];
      if (ctrlWr) ctrl   <= pWData[4:0];
    end
  end

  // Bit-clock generator; a DIV write restarts the count without toggling uClk
  logic [DIV_W-1:0] divCnt;
  logic             uClkQ, wrapNow, riseTick, fallTick;

  assign wrapNow  = ~divWr & (divCnt == divReg);
  assign riseTick = wrapNow & ~uClkQ;
  assign fallTick = wrapNow & uClkQ;
  assign uClk     = uClkQ;

  always_ff @(posedge pClk or negedge pReset) begin
    if (!pReset) begin
      divCnt <= '0;
      uClkQ  <= 1'b0;
    end else if (divWr) begin
      divCnt <= '0;
    end else if (wrapNow) begin
      divCnt <= '0;
      uClkQ  <= ~uClkQ;
    end else begin
      divCnt <= divCnt + 1'b1;
    end
  end

  // TX FIFO
  logic [DATA_W-1:0] txMem [FIFO_DEPTH];
  logic [PTR_W-1:0]  txWrPtr, txRdPtr;
  logic [CNT_W-1:0]  txCount;
  logic              txFull, txEmpty, txPush, txPop;

  assign txFull  = (txCount == FULL_CNT);
  assign txEmpty = (txCount == '0);
  assign txPush  = dataWr & ~txFull;

  always_ff @(posedge pClk) begin
    if (txPush) txMem[txWrPtr] <= pWData[DATA_W-1:0];
  end

  always_ff @(posedge pClk or negedge pReset) begin
    if (!pReset) begin
      txWrPtr <= '0;
      txRdPtr <= '0;
      txCount <= '0;
    end else begin
      if (txPush) txWrPtr <= txWrPtr + 1'b1;
      if (txPop)  txRdPtr <= txRdPtr + 1'b1;
      txCount <= txCount + CNT_W'(txPush) - CNT_W'(txPop);
    end
  end

  // RX FIFO
  logic [DATA_W-1:0] rxMem [FIFO_DEPTH];
  logic [PTR_W-1:0]  rxWrPtr, rxRdPtr;
  logic [CNT_W-1:0]  rxCount;
  logic              rxFull, rxEmpty, rxPush, rxPop, rxDone;
  logic [DATA_W-1:0] rxShift;

  assign rxFull  = (rxCount == FULL_CNT);
  assign rxEmpty = (rxCount == '0);
  assign rxPush  = rxDone & ~rxFull;
  assign rxPop   = dataRd & ~rxEmpty;

  always_ff @(posedge pClk) begin
    if (rxPush) rxMem[rxWrPtr] <= rxShift;
  end

  always_ff @(posedge pClk or negedge pReset) begin
    if (!pReset) begin
      rxWrPtr <= '0;
      rxRdPtr <= '0;
      rxCount <= '0;
    end else begin
      if (rxPush) rxWrPtr <= rxWrPtr + 1'b1;
      if (rxPop)  rxRdPtr <= rxRdPtr + 1'b1;
      rxCount <= rxCount + CNT_W'(rxPush) - CNT_W'(rxPop);
    end
  end

  // TX state register and datapath
  txState_t          txState, txNext;
  logic [DATA_W-1:0] txShift;
  logic [BIT_W-1:0]  txBitCnt;
  logic              txQ, txQNext, txShiftEn, txBitClr, txGo, txBusy;

  assign txGo   = txEn & ~txEmpty;
  assign txBusy = (txState != TX_IDLE);
  assign Tx     = txQ;

  always_ff @(posedge pClk or negedge pReset) begin
    if (!pReset) txState <= TX_IDLE;
    else         txState <= txNext;
  end

  // TX next state; a new frame is only started from IDLE or straight after STOP
  always_comb begin
    txNext    = txState;
    txQNext   = txQ;
    txPop     = 1'b0;
    txShiftEn = 1'b0;
    txBitClr  = 1'b0;
    if (fallTick) begin
      case (txState)
        TX_IDLE: begin
          if (txGo) begin
            txPop   = 1'b1;
            txQNext = 1'b0;
            txNext  = TX_START;
          end
        end
        TX_START: begin
          txQNext   = txShift[0];
          txShiftEn = 1'b1;
          txBitClr  = 1'b1;
          txNext    = TX_DATA;
        end
        TX_DATA: begin
          if (txBitCnt == LAST_BIT) begin
            txQNext = 1'b1;
            txNext  = TX_STOP;
          end else begin
            txQNext   = txShift[0];
            txShiftEn = 1'b1;
          end
        end
        TX_STOP: begin
          if (txGo) begin
            txPop   = 1'b1;
            txQNext = 1'b0;
            txNext  = TX_START;
          end else begin
            txQNext = 1'b1;
            txNext  = TX_IDLE;
          end
        end
        default: begin
          txQNext = 1'b1;
          txNext  = TX_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge pClk or negedge pReset) begin
    if (!pReset) begin
      txQ      <= 1'b1;
      txShift  <= '0;
      txBitCnt <= '0;
    end else begin
      txQ <= txQNext;
      if (txPop)          txShift <= txMem[txRdPtr];
      else if (txShiftEn) txShift <= txShift >> 1;
      if (txBitClr)       txBitCnt <= '0;
      else if (txShiftEn) txBitCnt <= txBitCnt + 1'b1;
    end
  end

  // RX input synchroniser; loopback taps the internal Tx register instead
  logic rxMeta, rxSync, rxSample;

  always_ff @(posedge pClk or negedge pReset) begin
    if (!pReset) begin
      rxMeta <= 1'b1;
      rxSync <= 1'b1;
    end else begin
      rxMeta <= Rx;
      rxSync <= rxMeta;
    end
  end

  assign rxSample = loopback ? txQ : rxSync;

  // RX state register and datapath
  rxState_t         rxState, rxNext;
  logic [BIT_W-1:0] rxBitCnt;
  logic             rxShiftEn, rxBitClr, rxFrameErr;

  always_ff @(posedge pClk or negedge pReset) begin
    if (!pReset) rxState <= RX_IDLE;
    else         rxState <= rxNext;
  end

  // RX next state; dropping rx_en aborts any frame in progress
  always_comb begin
    rxNext     = rxState;
    rxShiftEn  = 1'b0;
    rxBitClr   = 1'b0;
    rxDone     = 1'b0;
    rxFrameErr = 1'b0;
    if (!rxEn) begin
      rxNext = RX_IDLE;
    end else if (riseTick) begin
      case (rxState)
        RX_IDLE: begin
          if (!rxSample) begin
            rxBitClr = 1'b1;
            rxNext   = RX_DATA;
          end
        end
        RX_DATA: begin
          rxShiftEn = 1'b1;
          if (rxBitCnt == LAST_BIT) rxNext = RX_STOP;
        end
        RX_STOP: begin
          rxNext = RX_IDLE;
          if (rxSample) rxDone     = 1'b1;
          else          rxFrameErr = 1'b1;
        end
        default: rxNext = RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge pClk or negedge pReset) begin
    if (!pReset) begin
      rxShift  <= '0;
      rxBitCnt <= '0;
    end else begin
      if (rxShiftEn) rxShift <= (rxShift >> 1) | (DATA_W'(rxSample) << (DATA_W - 1));
      if (rxBitClr)       rxBitCnt <= '0;
      else if (rxShiftEn) rxBitCnt <= rxBitCnt + 1'b1;
    end
  end

  // Sticky error flags; a new error in the same cycle wins over a clear
  logic overrun, frameErr;

  always_ff @(posedge pClk or negedge pReset) begin
    if (!pReset) begin
      overrun  <= 1'b0;
      frameErr <= 1'b0;
    end else begin
      if (rxDone & rxFull)             overrun <= 1'b1;
      else if (statusWr & pWData[4])   overrun <= 1'b0;
      if (rxFrameErr)                  frameErr <= 1'b1;
      else if (statusWr & pWData[5])   frameErr <= 1'b0;
    end
  end

  // Read mux and error response
  logic [6:0] statusWord;
  assign statusWord = {txBusy, frameErr, overrun, rxEmpty, rxFull, txEmpty, txFull};

  always_comb begin
    pRData = '0;
    if (regRd) begin
      case (regSel)
        ADDR_DATA:   if (!rxEmpty) pRData = 16'(rxMem[rxRdPtr]);
        ADDR_STATUS: pRData = 16'(statusWord);
        ADDR_DIV:    pRData = 16'(divReg);
        default:     pRData = 16'(ctrl);
      endcase
    end
  end

  assign pSlvErr = (dataWr & txFull) | (dataRd & rxEmpty);
  assign irq     = (ieRx & ~rxEmpty) | (ieErr & (overrun | frameErr));

endmodule

// File: tb/tb_apb_usrt_fifo.sv
module tb_apb_usrt_fifo;

  localparam logic [3:0] A_DATA = 4'h0, A_STAT = 4'h4, A_DIV = 4'h8, A_CTRL = 4'hC;

  logic        pClk = 1'b0;
  logic        pReset;
  logic        pSelect, pEnable, pWrite;
  logic [3:0]  pAddress;
  logic [15:0] pWData, pRData;
  logic        pReady, pSlvErr;
  logic        Rx, Tx, uClk, irq;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int lastFall = 0;

  apb_usrt_fifo #(.DATA_W(8), .FIFO_DEPTH(4), .DIV_W(16), .DEFAULT_DIV(7)) dut (
    .pClk(pClk), .pReset(pReset), .pSelect(pSelect), .pEnable(pEnable),
    .pWrite(pWrite), .pAddress(pAddress), .pWData(pWData), .pRData(pRData),
    .pReady(pReady), .pSlvErr(pSlvErr), .Rx(Rx), .Tx(Tx), .uClk(uClk), .irq(irq)
  );

  always #5 pClk = ~pClk;
  always @(posedge pClk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic        wr;
    logic [3:0]  addr;
    logic [15:0] wdata;
    logic [15:0] expData;
    logic        expErr;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];
  logic [7:0] burst [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic apbWrite(input logic [3:0] a, input logic [15:0] d, output logic err);
    @(negedge pClk);
    pSelect = 1'b1; pEnable = 1'b0; pWrite = 1'b1; pAddress = a; pWData = d;
    @(negedge pClk);
    pEnable = 1'b1;
    #1 err = pSlvErr;
    @(negedge pClk);
    pSelect = 1'b0; pEnable = 1'b0; pWrite = 1'b0;
  endtask

  task automatic apbRead(input logic [3:0] a, output logic [15:0] d, output logic err);
    @(negedge pClk);
    pSelect = 1'b1; pEnable = 1'b0; pWrite = 1'b0; pAddress = a;
    @(negedge pClk);
    pEnable = 1'b1;
    #1 begin d = pRData; err = pSlvErr; end
    @(negedge pClk);
    pSelect = 1'b0; pEnable = 1'b0;
  endtask

  // Waits for the next uClk falling edge; Tx has its new value on return
  task automatic waitFall(input int budget);
    logic prev;
    bit   ok;
    ok = 1'b0;
    prev = uClk;
    for (int n = 0; n < budget; n++) begin
      @(negedge pClk);
      if (prev === 1'b1 && uClk === 1'b0) begin
        ok = 1'b1;
        lastFall = cyc;
        break;
      end
      prev = uClk;
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL uClk fall timeout: no falling edge within %0d cycles", budget);
    end
  endtask

  task automatic waitIrq(input string name, input int budget);
    for (int n = 0; n < budget; n++) begin
      @(negedge pClk);
      if (irq === 1'b1) break;
    end
    check(name, irq, 1);
  endtask

  function automatic logic frameBit(input logic [7:0] d, input int k);
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return d[k-1];
  endfunction

  initial begin
    logic [15:0] rd;
    logic        err;
    logic [9:0]  a5Seq;
    logic [7:0]  feData;
    int          f0;

    pSelect = 0; pEnable = 0; pWrite = 0; pAddress = '0; pWData = '0; Rx = 1'b1;
    pReset = 1'b0;
    repeat (3) @(negedge pClk);
    check("reset Tx", Tx, 1);
    check("reset uClk", uClk, 0);
    check("reset pRData", pRData, 0);
    check("reset pSlvErr", pSlvErr, 0);
    check("reset irq", irq, 0);
    check("pReady", pReady, 1);
    pReset = 1'b1;
    @(negedge pClk);

    // register-level table
    vecs[0]  = '{1'b0, A_STAT, 16'h0000, 16'h000A, 1'b0};
    vecs[1]  = '{1'b0, A_DIV,  16'h0000, 16'h0007, 1'b0};
    vecs[2]  = '{1'b0, A_CTRL, 16'h0000, 16'h0000, 1'b0};
    vecs[3]  = '{1'b0, A_DATA, 16'h0000, 16'h0000, 1'b1};
    vecs[4]  = '{1'b1, A_DIV,  16'hBEEF, 16'h0000, 1'b0};
    vecs[5]  = '{1'b0, A_DIV,  16'h0000, 16'hBEEF, 1'b0};
    vecs[6]  = '{1'b1, A_CTRL, 16'hFFE0, 16'h0000, 1'b0};
    vecs[7]  = '{1'b0, A_CTRL, 16'h0000, 16'h0000, 1'b0};
    vecs[8]  = '{1'b1, A_CTRL, 16'h0018, 16'h0000, 1'b0};
    vecs[9]  = '{1'b0, A_CTRL, 16'h0000, 16'h0018, 1'b0};
    vecs[10] = '{1'b1, A_STAT, 16'h0030, 16'h0000, 1'b0};
    vecs[11] = '{1'b0, A_STAT, 16'h0000, 16'h000A, 1'b0};
    vecs[12] = '{1'b1, A_DIV,  16'h0001, 16'h0000, 1'b0};
    vecs[13] = '{1'b0, A_DIV,  16'h0000, 16'h0001, 1'b0};
    for (int i = 0; i < NV; i++) begin
      if (vecs[i].wr) begin
        apbWrite(vecs[i].addr, vecs[i].wdata, err);
      end else begin
        apbRead(vecs[i].addr, rd, err);
        check($sformatf("vec%0d rdata", i), rd, vecs[i].expData);
      end
      check($sformatf("vec%0d slverr", i), err, vecs[i].expErr);
    end

    // single 0xA5 frame at DIV=1
    a5Seq = 10'b1101001010;
    apbWrite(A_CTRL, 16'h0001, err);
    apbWrite(A_DATA, 16'h00A5, err);
    check("a5 push err", err, 0);
    f0 = 0;
    for (int k = 0; k < 10; k++) begin
      waitFall(64);
      if (k == 0) f0 = lastFall;
      if (k == 1) check("uClk period", lastFall - f0, 4);
      check($sformatf("a5 bit%0d", k), Tx, a5Seq[k]);
    end
    waitFall(64);
    check("a5 idle Tx", Tx, 1);
    apbRead(A_STAT, rd, err);
    check("a5 status idle", rd, 16'h000A);

    // loopback single frame with RX interrupt
    apbWrite(A_CTRL, 16'h000F, err);
    apbWrite(A_DATA, 16'h003C, err);
    waitIrq("lb irq rise", 400);
    apbRead(A_DATA, rd, err);
    check("lb rdata", rd, 16'h003C);
    check("lb rd err", err, 0);
    check("lb irq fall", irq, 0);
    apbRead(A_DATA, rd, err);
    check("lb empty rdata", rd, 0);
    check("lb empty err", err, 1);

    // loopback overrun with 5 frames
    for (int i = 1; i <= 5; i++) begin
      apbWrite(A_DATA, 16'(i), err);
      check($sformatf("ovr push%0d err", i), err, 0);
    end
    repeat (300) @(negedge pClk);
    apbRead(A_STAT, rd, err);
    check("ovr status", rd, 16'h0016);
    for (int i = 1; i <= 4; i++) begin
      apbRead(A_DATA, rd, err);
      check($sformatf("ovr read%0d", i), rd, 16'(i));
    end
    apbRead(A_STAT, rd, err);
    check("ovr status drained", rd, 16'h001A);
    apbWrite(A_STAT, 16'h0010, err);
    apbRead(A_STAT, rd, err);
    check("ovr cleared", rd, 16'h000A);

    // TX FIFO full, then back-to-back transmission
    burst[0] = 8'h11; burst[1] = 8'h22; burst[2] = 8'h33; burst[3] = 8'h44;
    apbWrite(A_CTRL, 16'h0000, err);
    for (int i = 0; i < 4; i++) begin
      apbWrite(A_DATA, 16'(burst[i]), err);
      check($sformatf("fill%0d err", i), err, 0);
    end
    apbWrite(A_DATA, 16'h0055, err);
    check("fill overflow err", err, 1);
    apbRead(A_STAT, rd, err);
    check("fill status", rd, 16'h0009);
    apbWrite(A_CTRL, 16'h0001, err);
    for (int f = 0; f < 4; f++) begin
      for (int k = 0; k < 10; k++) begin
        waitFall(64);
        check($sformatf("b2b f%0d bit%0d", f, k), Tx, frameBit(burst[f], k));
      end
    end
    waitFall(64);
    check("b2b idle Tx", Tx, 1);
    apbRead(A_STAT, rd, err);
    check("b2b status", rd, 16'h000A);

    // external Rx frame with bad stop bit
    apbWrite(A_DIV, 16'h0003, err);
    apbWrite(A_CTRL, 16'h0012, err);
    feData = 8'h5A;
    for (int k = 0; k < 10; k++) begin
      waitFall(64);
      Rx = (k == 0 || k == 9) ? 1'b0 : feData[k-1];
    end
    waitFall(64);
    Rx = 1'b1;
    waitFall(64);
    waitFall(64);
    apbRead(A_STAT, rd, err);
    check("ferr status", rd, 16'h002A);
    check("ferr irq", irq, 1);
    apbWrite(A_STAT, 16'h0020, err);
    apbRead(A_STAT, rd, err);
    check("ferr cleared", rd, 16'h000A);
    check("ferr irq clear", irq, 0);

    // asynchronous reset in the middle of a frame
    apbWrite(A_DIV, 16'h0001, err);
    apbWrite(A_CTRL, 16'h000F, err);
    apbWrite(A_DATA, 16'h0077, err);
    apbWrite(A_DATA, 16'h0066, err);
    waitIrq("mid irq", 400);
    waitFall(64);
    check("mid start bit", Tx, 0);
    waitFall(64);
    check("mid bit0", Tx, 0);
    pReset = 1'b0;
    #1;
    check("mid reset Tx", Tx, 1);
    check("mid reset uClk", uClk, 0);
    check("mid reset irq", irq, 0);
    @(negedge pClk);
    pReset = 1'b1;
    apbRead(A_STAT, rd, err);
    check("mid reset status", rd, 16'h000A);
    apbRead(A_DIV, rd, err);
    check("mid reset div", rd, 16'h0007);
    apbRead(A_CTRL, rd, err);
    check("mid reset ctrl", rd, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
